// File: rtl/signed_array_mult_pipe_pkg.sv
// Shared definitions for the signed array multiplier slice.
//   M_DEF / N_DEF : default operand widths
//   prod_width()  : width of the full signed product of an M x N multiply
package signed_array_mult_pipe_pkg;

    localparam int M_DEF = 5;
    localparam int N_DEF = 5;

    // A full M x N signed product never overflows M+N bits.
    function automatic int prod_width(input int m, input int n);
        return m + n;
    endfunction

endpackage

// File: rtl/signed_array_mult_pipe_if.sv
// Operand/result bundle for signed_array_mult_pipe.
//   in_valid  : operands valid this cycle
//   a_in      : M-bit signed multiplicand
//   x_in      : N-bit signed multiplier
//   out_valid : product valid
//   product   : (M+N)-bit signed product
// master = producer of operands / consumer of results, slave = the multiplier.
interface signed_array_mult_pipe_if
    import signed_array_mult_pipe_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF
);
    localparam int PW = prod_width(M, N);

    logic          in_valid;
    logic [M-1:0]  a_in;
    logic [N-1:0]  x_in;
    logic          out_valid;
    logic [PW-1:0] product;

    modport master (
        output in_valid, a_in, x_in,
        input  out_valid, product
    );

    modport slave (
        input  in_valid, a_in, x_in,
        output out_valid, product
    );

endinterface

// File: rtl/signed_array_mult_pipe_mult_cell.sv
// One cell of the carry-save array multiplier.
//   x, a      : operand bits, ANDed to form the partial-product bit
//   sum_in    : sum from the cell above-left (same weight)
//   carry_in  : carry from the cell above (same weight)
//   sum_out   : full-adder sum
//   carry_out : full-adder carry
// Tying a (or x) to 1 turns the cell into a plain full adder.
module mult_cell (
    input  logic x,
    input  logic a,
    input  logic sum_in,
    input  logic carry_in,
    output logic sum_out,
    output logic carry_out
);

    logic pp;

    assign pp        = x & a;
    assign sum_out   = pp ^ sum_in ^ carry_in;
    assign carry_out = (pp & sum_in) | (pp & carry_in) | (sum_in & carry_in);

endmodule

// File: rtl/signed_array_mult_pipe.sv
// Two-stage pipelined signed M x N multiplier on a sign-magnitude core.
// Stage 1 registers the operands and valid; stage 2 forms magnitudes,
// multiplies them in a carry-save AND/full-adder array with a ripple final
// row, conditionally negates, and registers product / out_valid.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every pipeline register
//   bus   : slave side of signed_array_mult_pipe_if
// Latency 2 cycles, one operand pair per cycle, no backpressure. The product
// register only loads when a valid operand pair reaches it, else it holds.
module signed_array_mult_pipe
    import signed_array_mult_pipe_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    signed_array_mult_pipe_if.slave bus
);

    localparam int PW = prod_width(M, N);

    // ---------------- stage 1 registers ----------------
    logic [M-1:0]  a_reg;
    logic [N-1:0]  x_reg;
    logic          valid_s1_reg;

    // ---------------- stage 2 registers ----------------
    logic [PW-1:0] product_reg;
    logic          out_valid_reg;

    // ---------------- stage 2 combinational ----------------
    logic [M-1:0]  a_mag;
    logic [N-1:0]  x_mag;
    logic          sign_next;
    logic [PW-1:0] mag_prod;
    logic [PW-1:0] product_next;

    // Most-negative operands wrap to 100..0, which read unsigned is exactly
    // the required magnitude, so no extra bit is needed.
    assign a_mag     = a_reg[M-1] ? (~a_reg + M'(1)) : a_reg;
    assign x_mag     = x_reg[N-1] ? (~x_reg + N'(1)) : x_reg;
    assign sign_next = a_reg[M-1] ^ x_reg[N-1];

    // Array storage: row gi holds partial-product row for x_mag[gi]; cell
    // (gi, gj) has weight gi+gj. Single-bit unpacked elements keep each
    // cell's output a distinct net.
    logic sum_w   [N][M];
    logic carry_w [N][M];
    logic fin_sum   [M-1];
    logic fin_carry [M];

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < M; gj++) begin : g_col
                if (gi == 0) begin : g_first
                    mult_cell u_cell (
                        .x        (x_mag[0]),
                        .a        (a_mag[gj]),
                        .sum_in   (1'b0),
                        .carry_in (1'b0),
                        .sum_out  (sum_w[0][gj]),
                        .carry_out(carry_w[0][gj])
                    );
                end else if (gj == M - 1) begin : g_top
                    // Leftmost column has no sum from the row above.
                    mult_cell u_cell (
                        .x        (x_mag[gi]),
                        .a        (a_mag[gj]),
                        .sum_in   (1'b0),
                        .carry_in (carry_w[gi-1][gj]),
                        .sum_out  (sum_w[gi][gj]),
                        .carry_out(carry_w[gi][gj])
                    );
                end else begin : g_mid
                    // sum from (gi-1, gj+1) and carry from (gi-1, gj) both
                    // carry weight gi+gj.
                    mult_cell u_cell (
                        .x        (x_mag[gi]),
                        .a        (a_mag[gj]),
                        .sum_in   (sum_w[gi-1][gj+1]),
                        .carry_in (carry_w[gi-1][gj]),
                        .sum_out  (sum_w[gi][gj]),
                        .carry_out(carry_w[gi][gj])
                    );
                end
            end
        end

        // Final ripple row: adds the last row's carries to its shifted sums.
        assign fin_carry[0] = 1'b0;
        for (gi = 0; gi < M - 1; gi++) begin : g_final
            mult_cell u_fa (
                .x        (sum_w[N-1][gi+1]),
                .a        (1'b1),
                .sum_in   (carry_w[N-1][gi]),
                .carry_in (fin_carry[gi]),
                .sum_out  (fin_sum[gi]),
                .carry_out(fin_carry[gi+1])
            );
        end

        // Low N product bits fall straight out of column 0 of each row.
        for (gi = 0; gi < N; gi++) begin : g_low
            assign mag_prod[gi] = sum_w[gi][0];
        end
        for (gi = 0; gi < M - 1; gi++) begin : g_high
            assign mag_prod[N+gi] = fin_sum[gi];
        end
    endgenerate

    // The leftmost column only ever adds one partial-product bit to a zero
    // carry, so its carries are structurally 0; ORing the last one in keeps
    // the value unchanged and leaves no dangling cell output.
    assign mag_prod[PW-1] = fin_carry[M-1] | carry_w[N-1][M-1];

    // A zero magnitude negates back to zero, so s=1 with P=0 is harmless.
    assign product_next = sign_next ? (~mag_prod + PW'(1)) : mag_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            x_reg         <= '0;
            valid_s1_reg  <= 1'b0;
            product_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            a_reg         <= bus.a_in;
            x_reg         <= bus.x_in;
            valid_s1_reg  <= bus.in_valid;
            out_valid_reg <= valid_s1_reg;
            if (valid_s1_reg) begin
                product_reg <= product_next;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.product   = product_reg;

endmodule

// File: tb/tb_signed_array_mult_pipe.sv
// Directed and exhaustive checks for signed_array_mult_pipe (M=N=5).
// Inputs are driven and outputs sampled on the falling edge.
module tb_signed_array_mult_pipe;

    localparam int M  = 5;
    localparam int N  = 5;
    localparam int PW = M + N;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    signed_array_mult_pipe_if #(.M(M), .N(N)) bus ();

    signed_array_mult_pipe #(.M(M), .N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand pair, then a bubble; returns on the falling edge
    // where that pair's result is visible.
    task automatic run_single(input int a, input int x);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_in     = M'(a);
        bus.x_in     = N'(x);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (bus.product !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_product got=%h want=%h", bus.product, {PW{1'b0}});
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_single(3, 5);
        $display("[TB] txn basic a=3 x=5 product=%h valid=%b", bus.product, bus.out_valid);
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_valid got=%b want=1", bus.out_valid);
        end
        tests_run++;
        if (bus.product !== 10'h00F) begin
            tests_failed++;
            $display("[TB] FAIL basic_product got=%h want=00f", bus.product);
        end
        // valid must fall one cycle after the bubble reaches the output
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_valid_drop got=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_directed(input string name, input int ta[], input int tx[],
                                 input logic [PW-1:0] te[]);
        for (int i = 0; i < ta.size(); i++) begin
            run_single(ta[i], tx[i]);
            $display("[TB] txn %s a=%0d x=%0d product=%h", name, ta[i], tx[i], bus.product);
            tests_run++;
            if (bus.product !== te[i] || bus.out_valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL %s_%0d got=%h/%b want=%h/1", name, i,
                         bus.product, bus.out_valid, te[i]);
            end
        end
    endtask

    task automatic test_signs();
        test_directed("signs", '{-3, -3, 7}, '{5, -5, -1}, '{10'h3F1, 10'h00F, 10'h3F9});
    endtask

    task automatic test_extremes();
        test_directed("extreme", '{-16, -16, 15}, '{-16, 15, 15},
                      '{10'h100, 10'h310, 10'h0E1});
    endtask

    task automatic test_zero();
        test_directed("zero", '{0, -16}, '{-7, 0}, '{10'h000, 10'h000});
    endtask

    task automatic test_back_to_back();
        int              ba[4] = '{1, 2, -4, 5};
        int              bx[4] = '{1, -3, 4, -6};
        logic [PW-1:0]   be[4] = '{10'h001, 10'h3FA, 10'h3F0, 10'h3E2};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2 && c < 6) begin
                $display("[TB] txn b2b a=%0d x=%0d product=%h valid=%b",
                         ba[c-2], bx[c-2], bus.product, bus.out_valid);
                tests_run++;
                if (bus.product !== be[c-2] || bus.out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_%0d got=%h/%b want=%h/1", c - 2,
                             bus.product, bus.out_valid, be[c-2]);
                end
            end
            if (c == 6) begin
                tests_run++;
                if (bus.out_valid !== 1'b0 || bus.product !== 10'h3E2) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_hold got=%h/%b want=3e2/0",
                             bus.product, bus.out_valid);
                end
            end
            if (c < 4) begin
                bus.in_valid = 1'b1;
                bus.a_in     = M'(ba[c]);
                bus.x_in     = N'(bx[c]);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_in     = M'(3);
        bus.x_in     = N'(5);
        @(negedge clk);
        bus.a_in     = M'(7);
        bus.x_in     = N'(7);
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        $display("[TB] txn mid_reset product=%h valid=%b", bus.product, bus.out_valid);
        tests_run++;
        if (bus.product !== '0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_async got=%h/%b want=000/0",
                     bus.product, bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (bus.product !== '0 || bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL mid_reset_stale_%0d got=%h/%b want=000/0", c,
                         bus.product, bus.out_valid);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [PW-1:0] exp_q[$];
        int            a_q[$];
        int            x_q[$];
        int            fails_before;
        fails_before = tests_failed;
        for (int idx = 0; idx < 1026; idx++) begin
            @(negedge clk);
            if (idx >= 2) begin
                tests_run++;
                if (bus.product !== exp_q[0] || bus.out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL exhaustive a=%0d x=%0d got=%h/%b want=%h/1",
                             a_q[0], x_q[0], bus.product, bus.out_valid, exp_q[0]);
                end
                void'(exp_q.pop_front());
                void'(a_q.pop_front());
                void'(x_q.pop_front());
            end
            if (idx < 1024) begin
                int ai;
                int xi;
                ai = (idx >> 5) - 16;
                xi = (idx & 31) - 16;
                bus.in_valid = 1'b1;
                bus.a_in     = M'(ai);
                bus.x_in     = N'(xi);
                exp_q.push_back(PW'(ai * xi));
                a_q.push_back(ai);
                x_q.push_back(xi);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        $display("[TB] txn exhaustive 1024 pairs, %0d mismatched", tests_failed - fails_before);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.x_in     = '0;

        test_reset();
        test_basic();
        test_signs();
        test_extremes();
        test_zero();
        test_back_to_back();
        test_mid_reset();
        test_exhaustive();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/signed_array_mult_pipe.md
Name: signed_array_mult_pipe

Overview:
Registered signed (two's-complement) M x N array multiplier built on a sign-magnitude core:
- Each operand is converted to magnitude.
- Magnitudes are multiplied in an AND/full-adder carry-save array with a ripple final row.
- The result is conditionally negated.

It sits in the datapath as a fixed-latency, fully pipelined arithmetic unit with a valid strobe.

Parameters:
- M, default 5, width of operand a (signed).
- N, default 5, width of operand x (signed); M and N are independent, both >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on a_in/x_in are valid this cycle.
- a_in  input  M  signed multiplicand.
- x_in  input  N  signed multiplier.
- out_valid  output  1  product valid.
- product  output  M+N  signed product a_in * x_in.

Behaviour:
- Reset (asynchronous assert on rst_n low): all pipeline registers clear to 0; product = 0, out_valid = 0. Release is synchronous to clk.
- Stage 1, on clk rising edge: register a_in, x_in and in_valid.
- Stage 2, combinational between stage 1 and stage 2:
  - Magnitudes: |a| = a[M-1] ? (~a + 1) : a, taken mod 2^M and treated as unsigned. |x| is formed the same way with width N.
  - Most-negative input, e.g. -16 for M=5: the magnitude bit pattern 10000 is read unsigned as 16. This is correct.
  - Sign: s = a[M-1] XOR x[N-1].
  - Array, row 0: cells compute a[i]&x[0]; sum-in 0, carry-in 0.
  - Array, rows k = 1..N-1: each cell computes (a[j]&x[k]) + sum from row k-1, column j+1 + carry from row k-1, column j. The top column's sum-in is 0.
  - Final row: M-1 full adders ripple the row N-1 carries against the shifted sums, with carry-in 0.
  - Unsigned magnitude product P (M+N bits): P[i] = row i, column 0 sum for i < N; P[N..M+N-2] = final-row sums; P[M+N-1] = final-row carry-out.
  - Result = s ? (~P + 1) : P, mod 2^(M+N). This equals exact signed a*x for all inputs with no overflow. A zero product with s=1 yields 0.
- Output registering: product and out_valid are registered at the end of stage 2.
- Latency and throughput:
  - Latency is 2 cycles from an in_valid cycle to the out_valid cycle.
  - One new operand pair is accepted per cycle. There is no stall or backpressure.
  - The product register updates only when the stage-1 valid is 1; otherwise it holds its last value. out_valid follows the valid pipeline.
- Mid-operation reset: in-flight results are discarded, and outputs go to 0 immediately.

Decomposition:
- Shared package:
  - default widths M_DEF=5, N_DEF=5;
  - a localparam function for the product width M+N.
- One natural sub-module: mult_cell.
  - Inputs: x bit, a bit, sum-in, carry-in. Outputs: carry-out, sum-out.
  - Function: full adder of (x&a), sum-in and carry-in.
  - It is instantiated M*N times; the final-row full adders reuse it with the a bit or the x bit tied to 1.
- The conditional negate is a small generic function or inline logic in the top. No separate module is needed.

Test Plan:
- Basic positive case: reset then release, in_valid=1, a=3, x=5 -> two cycles later out_valid=1, product=15 (0x00F).
- Sign combinations: a=-3, x=5 -> product=-15 (0x3F1); a=-3, x=-5 -> 15; a=7, x=-1 -> -7 (0x3F9).
- Extremes: a=-16, x=-16 -> 256 (0x100); a=-16, x=15 -> -240 (0x310); a=15, x=15 -> 225 (0x0E1).
- Zero with negative sign: a=0, x=-7 -> 0; a=-16, x=0 -> 0.
- Throughput and hold: back-to-back in_valid for 4 cycles with (1,1), (2,-3), (-4,4), (5,-6) -> products 1, -6, -16, -30 on 4 consecutive cycles. A following in_valid=0 gap drops out_valid while product holds -30.
- Mid-operation reset: rst_n asserted low mid-cycle while valids are in flight -> product=0 and out_valid=0 immediately (asynchronous); no stale result appears after release.
- Exhaustive check: all 1024 (a,x) pairs for M=N=5 compared against a behavioural signed multiply.
